// File: rtl/fetch_redirect_ctrl_pkg.sv
// Shared types and constants for the instruction-fetch sequencer.
package fetch_redirect_ctrl_pkg;

    localparam int unsigned INSTR_W = 32;
    localparam int unsigned ADDR_W  = 32;
    localparam logic [ADDR_W-1:0] PC_STEP = 32'd4;

    typedef enum logic [1:0] {
        StBoot,
        StFetch,
        StStall,
        StKill
    } fetch_state_e;

    function automatic logic [ADDR_W-1:0] word_align(input logic [ADDR_W-1:0] addr);
        return {addr[ADDR_W-1:2], 2'b00};
    endfunction

endpackage

// File: rtl/fetch_redirect_ctrl_buffer.sv
// Output register plus one skid entry between instruction memory and IF/ID.
module fetch_buffer
    import fetch_redirect_ctrl_pkg::*;
(
    input  logic               clk,
    input  logic               rst_n,
    input  logic               i_load,
    input  logic [INSTR_W-1:0] i_load_instr,
    input  logic [ADDR_W-1:0]  i_load_pc,
    input  logic               i_consume,
    input  logic               i_flush,
    output logic               o_valid,
    output logic [INSTR_W-1:0] o_instr,
    output logic [ADDR_W-1:0]  o_pc,
    output logic               o_full
);

    logic               r_out_valid;
    logic [INSTR_W-1:0] r_out_instr;
    logic [ADDR_W-1:0]  r_out_pc;
    logic               r_skid_valid;
    logic [INSTR_W-1:0] r_skid_instr;
    logic [ADDR_W-1:0]  r_skid_pc;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out_valid  <= 1'b0;
            r_out_instr  <= '0;
            r_out_pc     <= '0;
            r_skid_valid <= 1'b0;
            r_skid_instr <= '0;
            r_skid_pc    <= '0;
        end else if (i_flush) begin
            r_out_valid  <= 1'b0;
            r_skid_valid <= 1'b0;
        end else if (!r_out_valid || i_consume) begin
            // Output slot frees up: skid drains first to keep program order.
            if (r_skid_valid) begin
                r_out_valid  <= 1'b1;
                r_out_instr  <= r_skid_instr;
                r_out_pc     <= r_skid_pc;
                r_skid_valid <= i_load;
                if (i_load) begin
                    r_skid_instr <= i_load_instr;
                    r_skid_pc    <= i_load_pc;
                end
            end else begin
                r_out_valid <= i_load;
                if (i_load) begin
                    r_out_instr <= i_load_instr;
                    r_out_pc    <= i_load_pc;
                end
            end
        end else if (i_load) begin
            r_skid_valid <= 1'b1;
            r_skid_instr <= i_load_instr;
            r_skid_pc    <= i_load_pc;
        end
    end

    assign o_valid = r_out_valid;
    assign o_instr = r_out_instr;
    assign o_pc    = r_out_pc;
    assign o_full  = r_skid_valid;

endmodule

// File: rtl/fetch_redirect_ctrl.sv
// Fetch sequencer: PC, imem req/ready handshake, redirect merge and pipeline flushes.
module fetch_redirect_ctrl
    import fetch_redirect_ctrl_pkg::*;
#(
    parameter logic [ADDR_W-1:0] RESET_PC = 32'h0000_0000
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               i_branch_taken,
    input  logic               i_jump,
    input  logic [ADDR_W-1:0]  i_branch_addr,
    input  logic [ADDR_W-1:0]  i_jump_addr,
    input  logic               i_stall_if,
    output logic               o_imem_req,
    output logic [ADDR_W-1:0]  o_imem_addr,
    input  logic               i_imem_ready,
    input  logic [INSTR_W-1:0] i_imem_rdata,
    output logic               o_if_valid,
    output logic [INSTR_W-1:0] o_if_instr,
    output logic [ADDR_W-1:0]  o_if_pc,
    output logic               o_flush_ifid,
    output logic               o_flush_idex,
    output logic               o_flush_exmem
);

    fetch_state_e      r_state;
    fetch_state_e      w_state_next;
    logic [ADDR_W-1:0] r_pc;
    logic [ADDR_W-1:0] w_pc_next;
    logic [ADDR_W-1:0] r_req_addr;
    logic [ADDR_W-1:0] w_req_addr_next;

    logic              w_redirect;
    logic [ADDR_W-1:0] w_target;
    logic              w_consume;
    logic              w_load;
    logic              w_skid_fill;
    logic              w_buf_full;

    assign w_redirect  = i_branch_taken | i_jump;
    assign w_target    = word_align(i_branch_taken ? i_branch_addr : i_jump_addr);
    assign w_consume   = o_if_valid & ~i_stall_if;
    assign w_load      = (r_state == StFetch) & i_imem_ready & ~w_redirect;
    // In FETCH the skid is always empty, so this load is the one that fills it.
    assign w_skid_fill = w_load & o_if_valid & ~w_consume;

    always_comb begin
        w_state_next    = r_state;
        w_pc_next       = r_pc;
        w_req_addr_next = r_req_addr;
        case (r_state)
            StBoot: begin
                w_state_next    = StFetch;
                w_pc_next       = w_redirect ? w_target : RESET_PC;
                w_req_addr_next = w_redirect ? w_target : RESET_PC;
            end
            StFetch: begin
                if (w_redirect) begin
                    w_pc_next = w_target;
                    if (i_imem_ready) begin
                        w_req_addr_next = w_target;
                    end else begin
                        w_state_next = StKill;
                    end
                end else if (i_imem_ready) begin
                    w_pc_next       = r_pc + PC_STEP;
                    w_req_addr_next = r_pc + PC_STEP;
                    w_state_next    = w_skid_fill ? StStall : StFetch;
                end
            end
            StStall: begin
                if (w_redirect) begin
                    w_state_next    = StFetch;
                    w_pc_next       = w_target;
                    w_req_addr_next = w_target;
                end else if (w_consume) begin
                    w_state_next    = StFetch;
                    w_req_addr_next = r_pc;
                end
            end
            StKill: begin
                if (w_redirect) begin
                    w_pc_next = w_target;
                    if (i_imem_ready) begin
                        w_state_next    = StFetch;
                        w_req_addr_next = w_target;
                    end
                end else if (i_imem_ready) begin
                    w_state_next    = StFetch;
                    w_req_addr_next = r_pc;
                end
            end
            default: w_state_next = StBoot;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= StBoot;
            r_pc       <= RESET_PC;
            r_req_addr <= RESET_PC;
        end else begin
            r_state    <= w_state_next;
            r_pc       <= w_pc_next;
            r_req_addr <= w_req_addr_next;
        end
    end

    fetch_buffer u_fetch_buffer (
        .clk          (clk),
        .rst_n        (rst_n),
        .i_load       (w_load),
        .i_load_instr (i_imem_rdata),
        .i_load_pc    (r_req_addr),
        .i_consume    (w_consume),
        .i_flush      (w_redirect),
        .o_valid      (o_if_valid),
        .o_instr      (o_if_instr),
        .o_pc         (o_if_pc),
        .o_full       (w_buf_full)
    );

    assign o_imem_req    = (r_state == StFetch) || (r_state == StKill);
    assign o_imem_addr   = r_req_addr;
    assign o_flush_ifid  = w_redirect;
    assign o_flush_idex  = w_redirect;
    assign o_flush_exmem = w_redirect;

    logic w_unused;
    assign w_unused = w_buf_full;

endmodule

// File: tb/tb_fetch_redirect_ctrl.sv
// Directed bench for fetch_redirect_ctrl; memory returns addr ^ 0xDEAD0000.
module tb_fetch_redirect_ctrl;

    logic        clk;
    logic        rst_n;
    logic        branch_taken;
    logic        jump;
    logic [31:0] branch_addr;
    logic [31:0] jump_addr;
    logic        stall_if;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ready;
    logic [31:0] imem_rdata;
    logic        if_valid;
    logic [31:0] if_instr;
    logic [31:0] if_pc;
    logic        flush_ifid;
    logic        flush_idex;
    logic        flush_exmem;

    int total;
    int bad;

    fetch_redirect_ctrl #(.RESET_PC(32'h0000_0000)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .i_branch_taken(branch_taken),
        .i_jump        (jump),
        .i_branch_addr (branch_addr),
        .i_jump_addr   (jump_addr),
        .i_stall_if    (stall_if),
        .o_imem_req    (imem_req),
        .o_imem_addr   (imem_addr),
        .i_imem_ready  (imem_ready),
        .i_imem_rdata  (imem_rdata),
        .o_if_valid    (if_valid),
        .o_if_instr    (if_instr),
        .o_if_pc       (if_pc),
        .o_flush_ifid  (flush_ifid),
        .o_flush_idex  (flush_idex),
        .o_flush_exmem (flush_exmem)
    );

    assign imem_rdata = imem_addr ^ 32'hDEAD_0000;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic test_reset;
        @(negedge clk); #1;
        total++; if (imem_req !== 1'b0) begin bad++; $display("FAIL rst_req got=%b want=0", imem_req); end
        total++; if (imem_addr !== 32'h0) begin bad++; $display("FAIL rst_addr got=%h want=0", imem_addr); end
        total++; if (if_valid !== 1'b0) begin bad++; $display("FAIL rst_valid got=%b want=0", if_valid); end
        total++; if (if_instr !== 32'h0) begin bad++; $display("FAIL rst_instr got=%h want=0", if_instr); end
        total++; if (if_pc !== 32'h0) begin bad++; $display("FAIL rst_pc got=%h want=0", if_pc); end
        total++; if ({flush_ifid, flush_idex, flush_exmem} !== 3'b000) begin
            bad++; $display("FAIL rst_flush got=%b want=000", {flush_ifid, flush_idex, flush_exmem});
        end
    endtask

    task automatic test_stream;
        @(negedge clk); imem_ready = 1'b1; rst_n = 1'b1; #1;
        @(negedge clk); #1;
        total++; if (imem_req !== 1'b1) begin bad++; $display("FAIL stream_req0 got=%b want=1", imem_req); end
        total++; if (imem_addr !== 32'h0) begin bad++; $display("FAIL stream_addr0 got=%h want=0", imem_addr); end
        total++; if (if_valid !== 1'b0) begin bad++; $display("FAIL stream_valid0 got=%b want=0", if_valid); end
        @(negedge clk); #1;
        total++; if (imem_addr !== 32'h4) begin bad++; $display("FAIL stream_addr1 got=%h want=4", imem_addr); end
        total++; if (if_valid !== 1'b1) begin bad++; $display("FAIL stream_valid1 got=%b want=1", if_valid); end
        total++; if (if_pc !== 32'h0) begin bad++; $display("FAIL stream_pc1 got=%h want=0", if_pc); end
        total++; if (if_instr !== 32'hDEAD_0000) begin
            bad++; $display("FAIL stream_instr1 got=%h want=dead0000", if_instr);
        end
        @(negedge clk); #1;
        total++; if (imem_addr !== 32'h8) begin bad++; $display("FAIL stream_addr2 got=%h want=8", imem_addr); end
        total++; if (if_pc !== 32'h4) begin bad++; $display("FAIL stream_pc2 got=%h want=4", if_pc); end
    endtask

    task automatic test_stall;
        stall_if = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk); #1;
            total++; if (imem_req !== 1'b0) begin bad++; $display("FAIL stall_req%0d got=%b want=0", k, imem_req); end
            total++; if (if_pc !== 32'h4 || if_valid !== 1'b1) begin
                bad++; $display("FAIL stall_hold%0d got=%h/%b want=4/1", k, if_pc, if_valid);
            end
        end
        stall_if = 1'b0;
        @(negedge clk); #1;
        total++; if (if_pc !== 32'h8 || if_valid !== 1'b1) begin
            bad++; $display("FAIL stall_rel_pc got=%h/%b want=8/1", if_pc, if_valid);
        end
        total++; if (imem_req !== 1'b1 || imem_addr !== 32'hC) begin
            bad++; $display("FAIL stall_rel_addr got=%b/%h want=1/c", imem_req, imem_addr);
        end
        @(negedge clk); #1;
        total++; if (if_pc !== 32'hC || if_instr !== 32'hDEAD_000C) begin
            bad++; $display("FAIL stall_next got=%h/%h want=c/dead000c", if_pc, if_instr);
        end
        total++; if (imem_addr !== 32'h10) begin bad++; $display("FAIL stall_next_addr got=%h want=10", imem_addr); end
    endtask

    task automatic test_redirect_both;
        branch_taken = 1'b1; branch_addr = 32'h100; jump = 1'b1; jump_addr = 32'h200; #1;
        total++; if ({flush_ifid, flush_idex, flush_exmem} !== 3'b111) begin
            bad++; $display("FAIL both_flush got=%b want=111", {flush_ifid, flush_idex, flush_exmem});
        end
        @(negedge clk); branch_taken = 1'b0; jump = 1'b0; #1;
        total++; if ({flush_ifid, flush_idex, flush_exmem} !== 3'b000) begin
            bad++; $display("FAIL both_flush_off got=%b want=000", {flush_ifid, flush_idex, flush_exmem});
        end
        total++; if (imem_req !== 1'b1 || imem_addr !== 32'h100) begin
            bad++; $display("FAIL both_addr got=%b/%h want=1/100", imem_req, imem_addr);
        end
        total++; if (if_valid !== 1'b0) begin bad++; $display("FAIL both_valid got=%b want=0", if_valid); end
        @(negedge clk); #1;
        total++; if (if_valid !== 1'b1 || if_pc !== 32'h100) begin
            bad++; $display("FAIL both_first got=%b/%h want=1/100", if_valid, if_pc);
        end
        total++; if (imem_addr !== 32'h104) begin bad++; $display("FAIL both_next got=%h want=104", imem_addr); end
    endtask

    task automatic test_kill;
        imem_ready = 1'b0; jump = 1'b1; jump_addr = 32'h10; #1;
        total++; if (flush_idex !== 1'b1) begin bad++; $display("FAIL kill_jflush got=%b want=1", flush_idex); end
        @(negedge clk); jump = 1'b0; #1;
        total++; if (imem_req !== 1'b1 || imem_addr !== 32'h104) begin
            bad++; $display("FAIL kill_hold got=%b/%h want=1/104", imem_req, imem_addr);
        end
        imem_ready = 1'b1;
        @(negedge clk); imem_ready = 1'b0; #1;
        total++; if (imem_addr !== 32'h10 || if_valid !== 1'b0) begin
            bad++; $display("FAIL kill_to10 got=%h/%b want=10/0", imem_addr, if_valid);
        end
        branch_taken = 1'b1; branch_addr = 32'h40;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk); branch_taken = 1'b0; #1;
            total++; if (imem_req !== 1'b1 || imem_addr !== 32'h10 || if_valid !== 1'b0) begin
                bad++; $display("FAIL kill_wait%0d got=%b/%h/%b want=1/10/0", k, imem_req, imem_addr, if_valid);
            end
        end
        imem_ready = 1'b1;
        @(negedge clk); #1;
        total++; if (imem_addr !== 32'h40 || if_valid !== 1'b0) begin
            bad++; $display("FAIL kill_drop got=%h/%b want=40/0", imem_addr, if_valid);
        end
        @(negedge clk); #1;
        total++; if (if_valid !== 1'b1 || if_pc !== 32'h40 || if_instr !== 32'hDEAD_0040) begin
            bad++; $display("FAIL kill_new got=%b/%h/%h want=1/40/dead0040", if_valid, if_pc, if_instr);
        end
    endtask

    task automatic test_redirect_full;
        stall_if = 1'b1;
        @(negedge clk); #1;
        total++; if (imem_req !== 1'b0 || if_pc !== 32'h40) begin
            bad++; $display("FAIL full_stall got=%b/%h want=0/40", imem_req, if_pc);
        end
        branch_taken = 1'b1; branch_addr = 32'h43; #1;
        total++; if ({flush_ifid, flush_idex, flush_exmem} !== 3'b111) begin
            bad++; $display("FAIL full_flush got=%b want=111", {flush_ifid, flush_idex, flush_exmem});
        end
        @(negedge clk); branch_taken = 1'b0; #1;
        total++; if ({flush_ifid, flush_idex, flush_exmem} !== 3'b000) begin
            bad++; $display("FAIL full_flush_once got=%b want=000", {flush_ifid, flush_idex, flush_exmem});
        end
        total++; if (if_valid !== 1'b0) begin bad++; $display("FAIL full_clear got=%b want=0", if_valid); end
        total++; if (imem_req !== 1'b1 || imem_addr !== 32'h40) begin
            bad++; $display("FAIL full_addr got=%b/%h want=1/40", imem_req, imem_addr);
        end
        @(negedge clk); #1;
        total++; if (if_valid !== 1'b1 || if_pc !== 32'h40) begin
            bad++; $display("FAIL full_reload got=%b/%h want=1/40", if_valid, if_pc);
        end
    endtask

    task automatic test_reset_kill;
        stall_if = 1'b0; imem_ready = 1'b0; jump = 1'b1; jump_addr = 32'h80;
        @(negedge clk); jump = 1'b0; #1;
        total++; if (imem_req !== 1'b1 || imem_addr !== 32'h44 || if_valid !== 1'b0) begin
            bad++; $display("FAIL rk_kill got=%b/%h/%b want=1/44/0", imem_req, imem_addr, if_valid);
        end
        #2; rst_n = 1'b0; #1;
        total++; if (imem_req !== 1'b0 || imem_addr !== 32'h0) begin
            bad++; $display("FAIL rk_async got=%b/%h want=0/0", imem_req, imem_addr);
        end
        total++; if (if_valid !== 1'b0 || if_pc !== 32'h0) begin
            bad++; $display("FAIL rk_async_if got=%b/%h want=0/0", if_valid, if_pc);
        end
        imem_ready = 1'b1;
        repeat (2) @(negedge clk);
        #1;
        total++; if (imem_req !== 1'b0 || if_valid !== 1'b0) begin
            bad++; $display("FAIL rk_held got=%b/%b want=0/0", imem_req, if_valid);
        end
        rst_n = 1'b1;
        @(negedge clk); #1;
        total++; if (imem_req !== 1'b1 || imem_addr !== 32'h0 || if_valid !== 1'b0) begin
            bad++; $display("FAIL rk_first got=%b/%h/%b want=1/0/0", imem_req, imem_addr, if_valid);
        end
        @(negedge clk); #1;
        total++; if (if_valid !== 1'b1 || if_pc !== 32'h0 || imem_addr !== 32'h4) begin
            bad++; $display("FAIL rk_resume got=%b/%h/%h want=1/0/4", if_valid, if_pc, imem_addr);
        end
    endtask

    initial begin
        total = 0;
        bad = 0;
        rst_n = 1'b0;
        branch_taken = 1'b0;
        jump = 1'b0;
        branch_addr = 32'h0;
        jump_addr = 32'h0;
        stall_if = 1'b0;
        imem_ready = 1'b0;
        test_reset();
        test_stream();
        test_stall();
        test_redirect_both();
        test_kill();
        test_redirect_full();
        test_reset_kill();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
